instr_decode_seq: RTL and testbench
===================================

Name: instr_decode_seq

Overview:
Parametrised successor to the single-shot decoder: an RV32I instruction decoder with an input instruction FIFO, valid/ready back-pressure, and full immediate generation for I/S/B/U/J formats.
Source registers are issued sequentially over one shared read-address channel (rs1, then rs2 when the format needs it).
The decoded op is then presented and held until the execute stage returns op_done.
Sits between fetch and execute/register file.

Parameters:
XLEN, 32, immediate/data width (sign-extension target)
INSTR_WIDTH, 32, instruction word width
OPCODE_WIDTH, 11, decoded opcode width: {funct7[5], funct3, opcode[6:0]}
ADDR_WIDTH, 5, register address width
FIFO_DEPTH, 4, instruction FIFO entries; power of 2, >= 2

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous abort: drop FIFO and current op
instr_valid  in  1  fetch presents instr
instr  in  INSTR_WIDTH  instruction word
instr_ready  out  1  FIFO can accept; push = instr_valid && instr_ready
op_done  in  1  execute finished current decoded op
imme_value  out  XLEN  sign-extended immediate
opcode  out  OPCODE_WIDTH  decoded opcode
rd_addr  out  ADDR_WIDTH  destination register
rs_addr  out  ADDR_WIDTH  source register being requested
rs_addr_sel  out  1  0 = rs1, 1 = rs2
rs_addr_valid  out  1  rs_addr valid this cycle
decode_valid  out  1  opcode/imme_value/rd_addr valid, held until op_done
illegal_instr  out  1  unsupported major opcode; qualified by decode_valid
fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async): FIFO empty, state IDLE, all outputs 0; instr_ready = 0 while rst is high.
- instr_ready = (fifo_count < FIFO_DEPTH) && !rst. There is no pop-to-push bypass when full.
- Simultaneous push and pop: count unchanged.
- FSM states: IDLE, RS1, RS2, ISSUE.
  - IDLE: if fifo_count > 0, pop into the decode register; next state is RS1 for R/I/S/B/load/JALR/SYSTEM, ISSUE for LUI/AUIPC/JAL/illegal.
  - RS1: rs_addr = instr[19:15], sel = 0, valid = 1, for exactly 1 cycle. Next state RS2 for R/S/B, else ISSUE.
  - RS2: rs_addr = instr[24:20], sel = 1, valid = 1, for 1 cycle; then ISSUE.
  - ISSUE: decode_valid = 1; opcode/imme_value/rd_addr/illegal_instr held stable. On op_done: if FIFO is non-empty, pop and go directly to RS1/ISSUE (back-to-back), else go to IDLE.
  - op_done is ignored outside ISSUE.
- Outputs are registered from state. rs_addr/rs_addr_sel are 0 when rs_addr_valid = 0. Decoded fields are 0 when decode_valid = 0.
- Latency from the push cycle (c0), FIFO empty and FSM idle:
  - R/S/B: RS1 in c2, RS2 in c3, ISSUE in c4.
  - I-type: RS1 in c2, ISSUE in c3.
  - U/J: ISSUE in c2.
- Opcode packing: funct7[5] is kept only for R-type and the I-type shifts (funct3 = 101); otherwise it is 0. funct3 is forced to 0 for LUI/AUIPC/JAL.
- Immediates, sign-extended from instr[31] to XLEN:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
  - R: 0
- rd_addr = instr[11:7] for formats that write; 0 for S/B.
- Illegal instruction: major opcode not in the RV32I set → ISSUE with illegal_instr = 1, other decoded fields 0; still waits for op_done.
- flush: highest priority after rst. Next cycle: FIFO empty, state IDLE, outputs 0. A push in the flush cycle is discarded.
- Reset asserted mid-op: immediate return to the reset state; no partial op survives.

Decomposition:
- decoder_pkg: RV32I major-opcode constants (OPC_LUI=7'b0110111, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_SYSTEM), format enum {FMT_R,FMT_I,FMT_S,FMT_B,FMT_U,FMT_J,FMT_ILL}, FSM state enum, and an imm_gen function.
- Sub-module: instr_fifo (synchronous FIFO, DEPTH/WIDTH parametrised, with count and flush).

Test Plan:
- ADD x3,x1,x2 (0x002081B3), op_done low → c2 rs_addr=1/sel=0; c3 rs_addr=2/sel=1; c4 decode_valid=1, opcode=11'h033, rd=3, imm=0; held until op_done.
- SUB x3,x1,x2 (0x402081B3) → opcode=11'h433. ADDI x5,x0,-1 (0xFFF00293) → RS1 rs_addr=0, no RS2, c3 ISSUE, imm=0xFFFFFFFF, rd=5, opcode=11'h013.
- LUI x1,0x12345 (0x123450B7) → no rs_addr_valid; c2 ISSUE, imm=0x12345000, rd=1, opcode=11'h037.
- BEQ x1,x2,-4 (0xFE208EE3) → RS1 + RS2; imm=0xFFFFFFFC, rd=0.
- Then push 6 back-to-back with op_done low, FIFO_DEPTH=4 → 5 accepted, fifo_count=4, instr_ready=0; pulse op_done → next op pops with no IDLE gap and instr_ready re-asserts.
- 0x00000000 → ISSUE with illegal_instr=1, opcode=0. Assert flush during RS2 with fifo_count=3 → next cycle all outputs 0, count 0.
- Assert rst during ISSUE → outputs 0 asynchronously.

Source files
------------

// File: rtl/instr_decode_seq_pkg.sv
// Shared RV32I decode definitions: major opcodes, format/state enums and the
// pure decode helpers used by the sequencer.
package instr_decode_seq_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL} fmt_e;

    typedef enum logic [1:0] {ST_IDLE, ST_RS1, ST_RS2, ST_ISSUE} state_e;

    typedef struct packed {
        logic [10:0] opc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        illegal;
    } issue_t;

    typedef struct packed {
        logic       need_rs1;
        logic       need_rs2;
        logic [4:0] rs1;
        logic [4:0] rs2;
        issue_t     iss;
    } dec_t;

    function automatic fmt_e get_fmt(input logic [6:0] opc);
        case (opc)
            OPC_OP:                                   return FMT_R;
            OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: return FMT_I;
            OPC_STORE:                                return FMT_S;
            OPC_BRANCH:                               return FMT_B;
            OPC_LUI, OPC_AUIPC:                       return FMT_U;
            OPC_JAL:                                  return FMT_J;
            default:                                  return FMT_ILL;
        endcase
    endfunction

    function automatic logic [31:0] imm_gen(input fmt_e fmt, input logic [31:0] w);
        case (fmt)
            FMT_I:   return {{20{w[31]}}, w[31:20]};
            FMT_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
            FMT_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            FMT_U:   return {w[31:12], 12'b0};
            FMT_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'b0;
        endcase
    endfunction

    function automatic dec_t decode(input logic [31:0] w);
        dec_t       d;
        fmt_e       fmt;
        logic       f7b5;
        logic [2:0] f3;
        fmt  = get_fmt(w[6:0]);
        d    = '0;
        // funct7[5] only distinguishes ADD/SUB, SRL/SRA and SRLI/SRAI
        f7b5 = ((fmt == FMT_R) || (w[6:0] == OPC_OPIMM && w[14:12] == 3'b101)) ? w[30] : 1'b0;
        f3   = (fmt == FMT_U || fmt == FMT_J) ? 3'b000 : w[14:12];
        if (fmt == FMT_ILL) begin
            d.iss.illegal = 1'b1;
        end else begin
            d.iss.opc = {f7b5, f3, w[6:0]};
            d.iss.imm = imm_gen(fmt, w);
            d.iss.rd  = (fmt == FMT_S || fmt == FMT_B) ? 5'd0 : w[11:7];
            d.need_rs1 = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
            d.need_rs2 = fmt inside {FMT_R, FMT_S, FMT_B};
            d.rs1 = w[19:15];
            d.rs2 = w[24:20];
        end
        return d;
    endfunction

endpackage

// File: rtl/instr_decode_seq_if.sv
// Fetch/execute-facing bundle of the decode sequencer; the decoder is the
// slave, the surrounding pipeline (or bench) is the master.
interface instr_decode_seq_if #(
    parameter int XLEN         = 32,
    parameter int INSTR_WIDTH  = 32,
    parameter int OPCODE_WIDTH = 11,
    parameter int ADDR_WIDTH   = 5,
    parameter int FIFO_DEPTH   = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                    flush;
    logic                    instr_valid;
    logic [INSTR_WIDTH-1:0]  instr;
    logic                    instr_ready;
    logic                    op_done;
    logic [XLEN-1:0]         imme_value;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [ADDR_WIDTH-1:0]   rs_addr;
    logic                    rs_addr_sel;
    logic                    rs_addr_valid;
    logic                    decode_valid;
    logic                    illegal_instr;
    logic [CNT_W-1:0]        fifo_count;

    modport master (
        output flush, instr_valid, instr, op_done,
        input  instr_ready, imme_value, opcode, rd_addr, rs_addr, rs_addr_sel,
               rs_addr_valid, decode_valid, illegal_instr, fifo_count
    );

    modport slave (
        input  flush, instr_valid, instr, op_done,
        output instr_ready, imme_value, opcode, rd_addr, rs_addr, rs_addr_sel,
               rs_addr_valid, decode_valid, illegal_instr, fifo_count
    );
endinterface

// File: rtl/instr_decode_seq_fifo.sv
// Synchronous instruction FIFO with occupancy count and synchronous flush.
// Read data is the head entry, valid whenever count_o is non-zero.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i && (count_q < CW'(DEPTH)) && !flush_i;
    assign pop_ok  = pop_i && (count_q != '0) && !flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; entries are only read once counted in.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_decode_seq.sv
// RV32I decode sequencer: buffers fetched words, issues rs1/rs2 reads over one
// shared address channel, then holds the decoded op until execute retires it.
//
// state    | meaning
// ST_IDLE  | no op in flight, waiting for a FIFO entry
// ST_RS1   | rs1 address presented for one cycle
// ST_RS2   | rs2 address presented for one cycle
// ST_ISSUE | decoded op held until op_done
module instr_decode_seq
    import instr_decode_seq_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int INSTR_WIDTH  = 32,
    parameter int OPCODE_WIDTH = 11,
    parameter int ADDR_WIDTH   = 5,
    parameter int FIFO_DEPTH   = 4
) (
    input logic                 clk,
    input logic                 rst,
    instr_decode_seq_if.slave   bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0]           fifo_count;
    logic [INSTR_WIDTH-1:0]  fifo_head;
    logic                    ready;
    logic                    push;
    logic                    start_op;
    logic                    enter_issue;
    dec_t                    head_dec;
    issue_t                  issue_src;

    state_e                  state_q;
    issue_t                  cur_q;
    logic [4:0]              cur_rs2_q;
    logic                    cur_need_rs2_q;
    logic                    rs_valid_q;
    logic                    rs_sel_q;
    logic [ADDR_WIDTH-1:0]   rs_addr_q;
    logic                    dv_q;
    logic                    ill_q;
    logic [OPCODE_WIDTH-1:0] opc_q;
    logic [XLEN-1:0]         imm_q;
    logic [ADDR_WIDTH-1:0]   rd_q;

    assign ready    = (fifo_count < CW'(FIFO_DEPTH)) && !rst;
    assign push     = bus.instr_valid && ready && !bus.flush;
    assign start_op = (fifo_count != '0) && !bus.flush &&
                      (state_q == ST_IDLE || (state_q == ST_ISSUE && bus.op_done));
    assign head_dec = decode(32'(fifo_head));
    assign issue_src = start_op ? head_dec.iss : cur_q;
    assign enter_issue = (state_q == ST_RS1 && !cur_need_rs2_q) || (state_q == ST_RS2) ||
                         (start_op && !head_dec.need_rs1);

    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.flush),
        .push_i  (push),
        .wdata_i (bus.instr),
        .pop_i   (start_op),
        .rdata_o (fifo_head),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cur_q          <= '0;
            cur_rs2_q      <= '0;
            cur_need_rs2_q <= 1'b0;
            rs_valid_q     <= 1'b0;
            rs_sel_q       <= 1'b0;
            rs_addr_q      <= '0;
            dv_q           <= 1'b0;
            ill_q          <= 1'b0;
            opc_q          <= '0;
            imm_q          <= '0;
            rd_q           <= '0;
        end else if (bus.flush) begin
            state_q        <= ST_IDLE;
            cur_q          <= '0;
            cur_rs2_q      <= '0;
            cur_need_rs2_q <= 1'b0;
            rs_valid_q     <= 1'b0;
            rs_sel_q       <= 1'b0;
            rs_addr_q      <= '0;
            dv_q           <= 1'b0;
            ill_q          <= 1'b0;
            opc_q          <= '0;
            imm_q          <= '0;
            rd_q           <= '0;
        end else begin
            rs_valid_q <= 1'b0;
            rs_sel_q   <= 1'b0;
            rs_addr_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                end
                ST_RS1: begin
                    if (cur_need_rs2_q) begin
                        state_q    <= ST_RS2;
                        rs_valid_q <= 1'b1;
                        rs_sel_q   <= 1'b1;
                        rs_addr_q  <= ADDR_WIDTH'(cur_rs2_q);
                    end else begin
                        state_q <= ST_ISSUE;
                    end
                end
                ST_RS2: state_q <= ST_ISSUE;
                ST_ISSUE: begin
                    if (bus.op_done) begin
                        state_q <= ST_IDLE;
                        dv_q    <= 1'b0;
                        ill_q   <= 1'b0;
                        opc_q   <= '0;
                        imm_q   <= '0;
                        rd_q    <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // A new op may start in the same edge that retires the previous one.
            if (start_op) begin
                cur_q          <= head_dec.iss;
                cur_rs2_q      <= head_dec.rs2;
                cur_need_rs2_q <= head_dec.need_rs2;
                if (head_dec.need_rs1) begin
                    state_q    <= ST_RS1;
                    rs_valid_q <= 1'b1;
                    rs_addr_q  <= ADDR_WIDTH'(head_dec.rs1);
                end else begin
                    state_q <= ST_ISSUE;
                end
            end
            if (enter_issue) begin
                dv_q  <= 1'b1;
                ill_q <= issue_src.illegal;
                opc_q <= OPCODE_WIDTH'(issue_src.opc);
                imm_q <= XLEN'($signed(issue_src.imm));
                rd_q  <= ADDR_WIDTH'(issue_src.rd);
            end
        end
    end

    assign bus.instr_ready   = ready;
    assign bus.fifo_count    = fifo_count;
    assign bus.rs_addr_valid = rs_valid_q;
    assign bus.rs_addr_sel   = rs_sel_q;
    assign bus.rs_addr       = rs_addr_q;
    assign bus.decode_valid  = dv_q;
    assign bus.illegal_instr = ill_q;
    assign bus.opcode        = opc_q;
    assign bus.imme_value    = imm_q;
    assign bus.rd_addr       = rd_q;

endmodule

// File: tb/tb_instr_decode_seq.sv
// Bench for instr_decode_seq: directed literal cases plus random traffic,
// every cycle compared against a queue-based model of the decode sequence.
module tb_instr_decode_seq;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    instr_decode_seq_if #(.FIFO_DEPTH(DEPTH)) bus();
    instr_decode_seq #(.FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rv;
        logic [4:0]  ra;
        logic        sel;
        logic        dv;
        logic [10:0] opc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic [31:0] mq[$];   // instructions waiting in the FIFO
    exp_t        ph[$];   // remaining output phases of the op in flight

    // Expected output phases of one instruction, from the RV32I encoding rules.
    function automatic void start_ref(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        int   hi, imm;
        bit   u1, u2, wr, keep7, nof3, legal;
        exp_t e;
        op = w[6:0]; f3 = w[14:12];
        u1 = 0; u2 = 0; wr = 1; keep7 = 0; nof3 = 0; legal = 1; imm = 0;
        case (op)
            7'h13, 7'h03, 7'h67, 7'h73: begin
                u1 = 1; imm = $signed(w) >>> 20; keep7 = (op == 7'h13 && f3 == 3'd5);
            end
            7'h33: begin u1 = 1; u2 = 1; keep7 = 1; end
            7'h23: begin
                u1 = 1; u2 = 1; wr = 0;
                hi = $signed(w) >>> 25; imm = hi * 32 + int'(w[11:7]);
            end
            7'h63: begin
                u1 = 1; u2 = 1; wr = 0;
                hi = $signed(w) >>> 31;
                imm = hi * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            end
            7'h37, 7'h17: begin nof3 = 1; imm = int'(w & 32'hFFFFF000); end
            7'h6F: begin
                nof3 = 1; hi = $signed(w) >>> 31;
                imm = hi * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            end
            default: legal = 0;
        endcase
        e = '0;
        if (!legal) begin
            e.dv = 1; e.ill = 1; ph.push_back(e);
            return;
        end
        if (u1) begin e.rv = 1; e.ra = w[19:15]; ph.push_back(e); end
        if (u2) begin e = '0; e.rv = 1; e.ra = w[24:20]; e.sel = 1; ph.push_back(e); end
        e = '0;
        e.dv  = 1;
        e.opc = {keep7 ? w[30] : 1'b0, nof3 ? 3'b000 : f3, op};
        e.imm = 32'(imm);
        e.rd  = wr ? w[11:7] : 5'd0;
        ph.push_back(e);
    endfunction

    always @(posedge clk) begin
        int n;
        if (rst || bus.flush) begin
            mq.delete();
            ph.delete();
        end else begin
            n = mq.size();
            if (ph.size() > 0) begin
                if (!ph[0].dv || bus.op_done) void'(ph.pop_front());
            end
            if (ph.size() == 0 && mq.size() > 0) start_ref(mq.pop_front());
            if (bus.instr_valid && n < DEPTH) mq.push_back(bus.instr);
        end
    end

    always @(negedge clk) begin
        exp_t       e, g;
        logic [2:0] ec;
        logic       er;
        if (rst || ph.size() == 0) e = '0;
        else e = ph[0];
        ec = rst ? 3'd0 : 3'(mq.size());
        er = !rst && (mq.size() < DEPTH);
        g = {bus.rs_addr_valid, bus.rs_addr, bus.rs_addr_sel, bus.decode_valid,
             bus.opcode, bus.imme_value, bus.rd_addr, bus.illegal_instr};
        checks++;
        if (g !== e || bus.fifo_count !== ec || bus.instr_ready !== er) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t got rv=%0b ra=%0d sel=%0b dv=%0b opc=%03h imm=%08h rd=%0d ill=%0b cnt=%0d rdy=%0b | exp rv=%0b ra=%0d sel=%0b dv=%0b opc=%03h imm=%08h rd=%0d ill=%0b cnt=%0d rdy=%0b",
                     $time, g.rv, g.ra, g.sel, g.dv, g.opc, g.imm, g.rd, g.ill, bus.fifo_count, bus.instr_ready,
                     e.rv, e.ra, e.sel, e.dv, e.opc, e.imm, e.rd, e.ill, ec, er);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        bus.instr_valid = 1'b1;
        bus.instr = w;
        tick();
        bus.instr_valid = 1'b0;
    endtask

    task automatic done_op();
        bus.op_done = 1'b1;
        tick();
        bus.op_done = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        logic [31:0] w;
        int          k;
        w = $urandom();
        k = $urandom_range(0, 11);
        if (k < 10) w[6:0] = ops[k];
        return w;
    endfunction

    logic [31:0] bb [6] = '{32'h002081B3, 32'hFFF00293, 32'h123450B7, 32'hFE208EE3,
                            32'h402081B3, 32'hFFF00293};

    initial begin
        bus.flush = 1'b0; bus.instr_valid = 1'b0; bus.instr = '0; bus.op_done = 1'b0;
        repeat (3) tick();
        lit("rst_ready", 32'(bus.instr_ready), 0);
        lit("rst_dv", 32'(bus.decode_valid), 0);
        lit("rst_cnt", 32'(bus.fifo_count), 0);
        rst = 1'b0;
        tick();

        // ADD x3,x1,x2
        push(32'h002081B3); tick();
        lit("add_rs1_v", 32'(bus.rs_addr_valid), 1);
        lit("add_rs1", 32'(bus.rs_addr), 1);
        lit("add_sel0", 32'(bus.rs_addr_sel), 0);
        tick();
        lit("add_rs2", 32'(bus.rs_addr), 2);
        lit("add_sel1", 32'(bus.rs_addr_sel), 1);
        tick();
        lit("add_dv", 32'(bus.decode_valid), 1);
        lit("add_opc", 32'(bus.opcode), 32'h033);
        lit("add_rd", 32'(bus.rd_addr), 3);
        lit("add_imm", bus.imme_value, 0);
        repeat (3) tick();
        lit("add_hold", 32'(bus.decode_valid), 1);
        done_op();
        lit("add_retired", 32'(bus.decode_valid), 0);

        // SUB x3,x1,x2
        push(32'h402081B3); repeat (3) tick();
        lit("sub_opc", 32'(bus.opcode), 32'h433);
        done_op();

        // ADDI x5,x0,-1
        push(32'hFFF00293); tick();
        lit("addi_rs1_v", 32'(bus.rs_addr_valid), 1);
        lit("addi_rs1", 32'(bus.rs_addr), 0);
        tick();
        lit("addi_dv", 32'(bus.decode_valid), 1);
        lit("addi_imm", bus.imme_value, 32'hFFFFFFFF);
        lit("addi_rd", 32'(bus.rd_addr), 5);
        lit("addi_opc", 32'(bus.opcode), 32'h013);
        done_op();

        // LUI x1,0x12345
        push(32'h123450B7); tick();
        lit("lui_dv", 32'(bus.decode_valid), 1);
        lit("lui_imm", bus.imme_value, 32'h12345000);
        lit("lui_rd", 32'(bus.rd_addr), 1);
        lit("lui_opc", 32'(bus.opcode), 32'h037);
        done_op();

        // BEQ x1,x2,-4
        push(32'hFE208EE3); tick();
        lit("beq_rs1", 32'(bus.rs_addr), 1);
        tick();
        lit("beq_rs2", 32'(bus.rs_addr), 2);
        tick();
        lit("beq_imm", bus.imme_value, 32'hFFFFFFFC);
        lit("beq_rd", 32'(bus.rd_addr), 0);
        lit("beq_opc", 32'(bus.opcode), 32'h063);
        done_op();

        // Six back-to-back pushes with execute stalled
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.instr = bb[i];
            tick();
        end
        bus.instr_valid = 1'b0;
        lit("bb_cnt_full", 32'(bus.fifo_count), 4);
        lit("bb_ready_low", 32'(bus.instr_ready), 0);
        done_op();
        lit("bb_no_gap", 32'(bus.rs_addr_valid), 1);
        lit("bb_cnt", 32'(bus.fifo_count), 3);
        lit("bb_ready", 32'(bus.instr_ready), 1);
        bus.op_done = 1'b1;
        repeat (30) tick();
        bus.op_done = 1'b0;
        lit("bb_drained", 32'(bus.fifo_count), 0);

        // Illegal all-zero word
        push(32'h00000000); tick();
        lit("ill_dv", 32'(bus.decode_valid), 1);
        lit("ill_flag", 32'(bus.illegal_instr), 1);
        lit("ill_opc", 32'(bus.opcode), 0);
        done_op();

        // Flush during RS2 with three entries queued
        push(32'h123450B7);
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.instr = 32'h002081B3 + (i << 7);
            tick();
        end
        bus.instr_valid = 1'b0;
        lit("fl_cnt4", 32'(bus.fifo_count), 4);
        done_op();
        tick();
        lit("fl_rs2", 32'(bus.rs_addr_sel), 1);
        lit("fl_cnt3", 32'(bus.fifo_count), 3);
        bus.flush = 1'b1; bus.instr_valid = 1'b1; bus.instr = 32'hFFF00293;
        tick();
        bus.flush = 1'b0; bus.instr_valid = 1'b0;
        lit("fl_cnt0", 32'(bus.fifo_count), 0);
        lit("fl_rsv", 32'(bus.rs_addr_valid), 0);
        lit("fl_dv", 32'(bus.decode_valid), 0);
        tick();
        lit("fl_push_dropped", 32'(bus.fifo_count), 0);

        // Reset asserted while an op is held in ISSUE
        push(32'h123450B7);
        push(32'h002081B3);
        lit("rst_mid_dv_pre", 32'(bus.decode_valid), 1);
        #2 rst = 1'b1;
        #1;
        lit("rst_mid_dv", 32'(bus.decode_valid), 0);
        lit("rst_mid_imm", bus.imme_value, 0);
        lit("rst_mid_rd", 32'(bus.rd_addr), 0);
        lit("rst_mid_cnt", 32'(bus.fifo_count), 0);
        lit("rst_mid_ready", 32'(bus.instr_ready), 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.instr_valid = ($urandom_range(0, 99) < 55);
            bus.instr       = rand_instr();
            bus.op_done     = ($urandom_range(0, 99) < 30);
            bus.flush       = ($urandom_range(0, 199) == 0);
            tick();
        end
        bus.instr_valid = 1'b0; bus.op_done = 1'b0; bus.flush = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
